// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
// Contents:
//   BUF_DEPTH  - number of holding-buffer entries
//   buf_idx_t  - ring index into the holding buffer
//   buf_cnt_t  - word count held in the buffer (0..3)
//   idx_next() - ring increment with wrap 2 -> 0
package fifo_stream_pkg;

    localparam int BUF_DEPTH = 3;

    typedef logic [1:0] buf_idx_t;
    typedef logic [1:0] buf_cnt_t;

    // Advance a ring index, wrapping from the last entry back to 0.
    function automatic buf_idx_t idx_next(input buf_idx_t idx);
        buf_idx_t nxt;
        if (idx == 2'(BUF_DEPTH - 1)) begin
            nxt = 2'd0;
        end else begin
            nxt = idx + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/stream_buf3.sv
// Three-entry ring register file holding prefetched FIFO words.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (clears storage too)
//   wr_en_i    - write wr_data_i into the slot at the write index
//   wr_data_i  - word to store
//   rd_en_i    - advance the read index (head consumed)
//   head_o     - word at the read index, taken straight from storage flops
module stream_buf3
    import fifo_stream_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DWIDTH-1:0] head_o
);

    logic [DWIDTH-1:0] mem_q [BUF_DEPTH];
    buf_idx_t          wr_idx_q;
    buf_idx_t          wr_idx_d;
    buf_idx_t          rd_idx_q;
    buf_idx_t          rd_idx_d;

    // Next-state for the write and read ring indices.
    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        if (wr_en_i) begin
            wr_idx_d = idx_next(wr_idx_q);
        end else begin
            wr_idx_d = wr_idx_q;
        end
        if (rd_en_i) begin
            rd_idx_d = idx_next(rd_idx_q);
        end else begin
            rd_idx_d = rd_idx_q;
        end
    end

    // Storage and index registers; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_idx_q <= 2'd0;
            rd_idx_q <= 2'd0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_idx_q] <= wr_data_i;
            end
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    assign head_o = mem_q[rd_idx_q];

endmodule

// File: rtl/fifo_stream_out.sv
// Read-side adapter for a 1-cycle-read-latency FIFO: turns read/empty/dout
// into a valid/ready stream, prefetching into a 3-entry holding buffer.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (shared with the FIFO)
//   fifo_empty  - FIFO empty flag
//   fifo_dout   - FIFO read data, valid the cycle after fifo_read
//   fifo_read   - read strobe to the FIFO (never depends on m_ready)
//   m_valid     - stream valid (registered)
//   m_ready     - stream sink ready
//   m_data      - stream data, buffer head (from storage flops)
//   occupancy   - words currently held in the buffer, 0..3
module fifo_stream_out
    import fifo_stream_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              fifo_read,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic [1:0]        occupancy
);

    buf_cnt_t   occ_q;
    buf_cnt_t   occ_d;
    logic       inflight_q;
    logic       m_valid_q;
    logic       pop_s;
    logic [2:0] level_s;
    logic [2:0] occ_sum_s;

    // Words held plus the word in flight; a read may issue only if that leaves a free slot.
    always_comb begin
        level_s   = {1'b0, occ_q} + {2'b00, inflight_q};
        fifo_read = 1'b0;
        if (!fifo_empty && (level_s < 3'(BUF_DEPTH))) begin
            fifo_read = 1'b1;
        end else begin
            fifo_read = 1'b0;
        end
    end

    // Occupancy bookkeeping: captured word enters, handshaken word leaves (3-bit math).
    always_comb begin
        pop_s     = m_valid_q && m_ready;
        occ_sum_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        occ_d     = occ_sum_s[1:0];
    end

    // Control registers; m_valid is registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_read;
            m_valid_q  <= (occ_d != 2'd0);
        end
    end

    // The word read last cycle is on fifo_dout now and is captured at this edge.
    stream_buf3 #(
        .DWIDTH (DWIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (inflight_q),
        .wr_data_i (fifo_dout),
        .rd_en_i   (pop_s),
        .head_o    (m_data)
    );

    assign m_valid   = m_valid_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_fifo_stream_out.sv
module tb_fifo_stream_out;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        fifo_read;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [1:0]  occupancy;

    int checks;
    int failures;

    // Upstream FIFO model contents and expected-stream scoreboard.
    logic [31:0] fq[$];
    logic [31:0] exp_q[$];

    // Values seen just before the most recent clock edge.
    logic        pre_rd;
    logic        pre_empty;
    logic        pre_hs;
    logic        pre_stall;
    logic [31:0] pre_data;

    fifo_stream_out #(.DWIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_read  (fifo_read),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: record pre-edge values, then advance the 1-cycle-latency FIFO model.
    task automatic tick();
        #1;
        pre_rd    = fifo_read;
        pre_empty = fifo_empty;
        pre_hs    = m_valid && m_ready;
        pre_stall = m_valid && !m_ready;
        pre_data  = m_data;
        @(posedge clk);
        #1;
        if (rst) begin
            fq.delete();
            fifo_dout = 32'd0;
        end else if (pre_rd && (fq.size() > 0)) begin
            fifo_dout = fq.pop_front();
        end
        fifo_empty = (fq.size() == 0);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", m_valid); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        checks++; if (m_data !== 32'd0) begin failures++; $display("FAIL reset_data: got %0h expected 0", m_data); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (fifo_read !== 1'b0 || m_valid !== 1'b0 || occupancy !== 2'd0) begin
                failures++;
                $display("FAIL idle: cycle %0d got read=%0b valid=%0b occ=%0d expected 0/0/0", i, fifo_read, m_valid, occupancy);
            end
        end
    endtask

    task automatic test_single();
        m_ready = 1'b1;
        push(32'hA5A5_0001);
        #1;
        checks++; if (fifo_read !== 1'b1) begin failures++; $display("FAIL single_read_c0: got %0b expected 1", fifo_read); end
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_valid_c1: got %0b expected 0", m_valid); end
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL single_c2: got valid=%0b data=%0h expected 1/a5a50001", m_valid, m_data);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL single_c3: got valid=%0b occ=%0d expected 0/0", m_valid, occupancy);
        end
    endtask

    task automatic test_burst();
        logic exp_v;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) push(32'(i));
        #1;
        for (int cyc = 0; cyc < 19; cyc++) begin
            exp_v = (cyc >= 2) && (cyc < 18);
            checks++;
            if (m_valid !== exp_v) begin
                failures++;
                $display("FAIL burst_valid: cycle %0d got %0b expected %0b", cyc, m_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (m_data !== 32'(cyc - 2)) begin
                    failures++;
                    $display("FAIL burst_data: cycle %0d got %0h expected %0h", cyc, m_data, cyc - 2);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int reads;
        reads = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(32'(i));
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick();
            if (pre_rd) reads++;
            if (m_valid) begin
                checks++;
                if (m_data !== 32'd0) begin
                    failures++;
                    $display("FAIL bp_hold_data: cycle %0d got %0h expected 0", cyc, m_data);
                end
            end
        end
        checks++; if (reads != 3) begin failures++; $display("FAIL bp_reads: got %0d expected 3", reads); end
        checks++; if (occupancy !== 2'd3) begin failures++; $display("FAIL bp_occ: got %0d expected 3", occupancy); end
        checks++; if (fifo_read !== 1'b0) begin failures++; $display("FAIL bp_read_stop: got %0b expected 0", fifo_read); end
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %0b expected 1", m_valid); end
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 32'(i)) begin
                failures++;
                $display("FAIL bp_drain: word %0d got valid=%0b data=%0h expected 1/%0h", i, m_valid, m_data, i);
            end
            tick();
        end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL bp_empty_after: got %0b expected 0", m_valid); end
    endtask

    task automatic test_random();
        int          pushed;
        int          delivered;
        int          issued;
        int          held;
        int          cycles;
        logic [31:0] w;
        pushed = 0;
        delivered = 0;
        issued = 0;
        cycles = 0;
        exp_q.delete();
        while (delivered < 1000 && cycles < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (pushed < 1000 && $urandom_range(0, 99) < 60) begin
                w = $urandom;
                push(w);
                exp_q.push_back(w);
                pushed++;
            end
            tick();
            cycles++;
            checks++;
            if (pre_rd && pre_empty) begin
                failures++;
                $display("FAIL rnd_read_empty: cycle %0d read issued while empty", cycles);
            end
            if (pre_hs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra_word: got %0h expected none", pre_data);
                end else begin
                    w = exp_q.pop_front();
                    if (pre_data !== w) begin
                        failures++;
                        $display("FAIL rnd_data: word %0d got %0h expected %0h", delivered, pre_data, w);
                    end
                end
                delivered++;
            end
            if (pre_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== pre_data) begin
                    failures++;
                    $display("FAIL rnd_stable: got valid=%0b data=%0h expected 1/%0h", m_valid, m_data, pre_data);
                end
            end
            // A read issued before the previous edge has landed in the buffer by now.
            held = issued - delivered;
            issued += pre_rd ? 1 : 0;
            checks++;
            if (held > 3 || {30'd0, occupancy} !== 32'(held)) begin
                failures++;
                $display("FAIL rnd_occ: cycle %0d got %0d expected %0d (max 3)", cycles, occupancy, held);
            end
        end
        checks++;
        if (delivered != 1000) begin
            failures++;
            $display("FAIL rnd_timeout: got %0d words expected 1000", delivered);
        end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h100 + 32'(i));
        tick();
        tick();
        tick();
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL mid_setup_occ: got %0d expected 2", occupancy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || occupancy !== 2'd0 || fifo_read !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got valid=%0b occ=%0d read=%0b expected 0/0/0", m_valid, occupancy, fifo_read);
        end
        m_ready = 1'b1;
        push(32'h1234_5678);
        #1;
        checks++; if (fifo_read !== 1'b1) begin failures++; $display("FAIL mid_read_c0: got %0b expected 1", fifo_read); end
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL mid_valid_c1: got %0b expected 0", m_valid); end
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL mid_c2: got valid=%0b data=%0h expected 1/12345678", m_valid, m_data);
        end
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL mid_c3: got %0b expected 0", m_valid); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout = 32'd0;
        m_ready = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
